mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide responder with architectural HI/LO registers for the multicycle MIPS core.
//   alu_control/alu issue MULT, MULTU, DIV and DIVU requests through the start/op handshake; this block
//   computes the result over 32 cycles and writes HI/LO. It also serves MFHI/MFLO reads and MTHI/MTLO writes.
//   It replaces the single-cycle 64-bit alu_result path for multiply/divide.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous reset, active-low
//   start      in   1   request pulse; sampled only in IDLE or DONE
//   op         in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a  in   32  rs value (multiplicand / dividend)
//   operand_b  in   32  rt value (multiplier / divisor)
//   hi_we      in   1   MTHI write strobe
//   lo_we      in   1   MTLO write strobe
//   wdata      in   32  MTHI/MTLO data
//   busy       out  1   high while state == CALC
//   done       out  1   one-cycle pulse, high in DONE
//   hi         out  32  HI register (MFHI source)
//   lo         out  32  LO register (MFLO source)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; internal counters/accumulators cleared.
//   FSM states and transitions:
//     IDLE -> CALC  when start=1; operands, op and sign flags are latched at that edge.
//     CALC -> CALC  while count < 31; count is incremented every cycle.
//     CALC -> DONE  when count == 31; hi/lo are written at this same edge.
//     DONE -> CALC  when start=1; otherwise DONE -> IDLE.
//   Latency: start sampled at edge N; hi/lo are valid and done=1 after edge N+33; done lasts 1 cycle.
//   Multiply: radix-2 shift-add on |a| and |b| (signed ops) or raw operands (unsigned ops).
//     Product is 64 bits. For MULT, the product is negated when a[31]^b[31]. {hi,lo} = product.
//   Divide: restoring division on magnitudes.
//     lo = quotient, hi = remainder.
//     DIV: quotient is negated if a[31]^b[31]; remainder takes the sign of the dividend (truncating division).
//     0x80000000 / 0xFFFFFFFF (DIV): lo = 0x80000000, hi = 0; no trap.
//     Divisor == 0, any divide op: still takes 32 cycles; lo = 0xFFFFFFFF, hi = operand_a.
//   start while busy=1: ignored. The in-flight operation is unaffected.
//   hi_we/lo_we:
//     In IDLE or DONE: write wdata at the edge, visible the next cycle.
//     While busy=1: dropped.
//     Same edge as an accepted start: the write is dropped and start wins.
//     hi_we and lo_we together: both registers are written.
//   hi/lo hold their value during CALC. The update is atomic at the CALC -> DONE edge.
//   Reset asserted mid-operation: immediate return to IDLE; hi = lo = 0; done is not pulsed.
// TESTING
//   T1 MULT a=0x80000000 b=2 -> done 33 cycles after start; {hi,lo} = 0xFFFFFFFF_00000000.
//   T2 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   T3 DIVU 11/4 -> hi=3, lo=2. DIV 0xFFFFFFF0/2 -> lo=0xFFFFFFF8, hi=0. DIV 9/-3 -> lo=0xFFFFFFFD, hi=0.
//   T4 DIV a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678, done at cycle 33.
//   T5 MULTU 3*5, then start DIVU 9/2 plus hi_we wdata=0xDEAD at cycle 10 of the MULTU ->
//      both ignored; hi=0, lo=15.
//      After done: lo_we wdata=0xBEEF -> lo=0xBEEF next cycle.
//   T6 Start MULT 7*7, drop rst_n at cycle 15 -> busy=0, hi=lo=0 immediately, no done pulse.
//      Release rst_n, MULT 7*7 -> lo=49.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
// One setup cycle takes operand magnitudes, then WIDTH shift-add or restoring-divide steps.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_prep;
   logic [CW-1:0]    r_count;
   logic             r_is_div;
   logic             r_sgn;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_mb;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH-1:0]   w_mul_acc;
   logic [WIDTH-1:0]   w_mul_q;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH:0]     w_div_sh;
   logic               w_div_ok;
   logic [WIDTH-1:0]   w_div_sub;
   logic [WIDTH-1:0]   w_div_acc;
   logic [WIDTH-1:0]   w_div_q;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_abs_a = (r_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_abs_b = (r_sgn && r_b[WIDTH-1]) ? -r_b : r_b;

   // Multiply step: conditionally add multiplicand to the upper half, then shift {acc,q} right.
   assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mb} : {(WIDTH+1){1'b0}});
   assign w_mul_acc = w_mul_sum[WIDTH:1];
   assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
   assign w_prod    = {w_mul_acc, w_mul_q};
   assign w_prod_s  = r_neg_q ? -w_prod : w_prod;

   // Restoring divide step: shift in next dividend bit, subtract divisor when it fits.
   assign w_div_sh  = {r_acc, r_q[WIDTH-1]};
   assign w_div_ok  = (w_div_sh >= {1'b0, r_mb});
   assign w_div_sub = w_div_sh[WIDTH-1:0] - r_mb;
   assign w_div_acc = w_div_ok ? w_div_sub : w_div_sh[WIDTH-1:0];
   assign w_div_q   = {r_q[WIDTH-2:0], w_div_ok};
   assign w_quo     = r_neg_q ? -w_div_q : w_div_q;
   assign w_rem     = r_neg_r ? -w_div_acc : w_div_acc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_prep   <= 1'b0;
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_sgn    <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_mb     <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state  <= S_CALC;
                  r_busy   <= 1'b1;
                  r_prep   <= 1'b1;
                  r_count  <= '0;
                  r_a      <= i_operand_a;
                  r_b      <= i_operand_b;
                  r_is_div <= i_op[1];
                  r_sgn    <= ~i_op[0];
                  r_neg_q  <= ~i_op[0] & (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]);
                  r_neg_r  <= i_op[1] & ~i_op[0] & i_operand_a[WIDTH-1];
               end else begin
                  r_state <= S_IDLE;
                  if (i_hi_we) r_hi <= i_wdata;
                  if (i_lo_we) r_lo <= i_wdata;
               end
            end
            S_CALC: begin
               if (r_prep) begin
                  r_prep <= 1'b0;
                  r_acc  <= '0;
                  r_q    <= r_is_div ? w_abs_a : w_abs_b;
                  r_mb   <= r_is_div ? w_abs_b : w_abs_a;
               end else begin
                  r_acc <= r_is_div ? w_div_acc : w_mul_acc;
                  r_q   <= r_is_div ? w_div_q : w_mul_q;
                  if (r_count == C_LAST) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_s;
                     end else if (r_b == '0) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                     end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                     end
                  end else begin
                     r_count <= r_count + C_ONE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic [1:0]  i_op;
   logic [31:0] i_operand_a;
   logic [31:0] i_operand_b;
   logic        i_hi_we;
   logic        i_lo_we;
   logic [31:0] i_wdata;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   int total = 0;
   int bad   = 0;
   int lat;

   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

   mult_div_unit #(.WIDTH(32)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_op        (i_op),
      .i_operand_a (i_operand_a),
      .i_operand_b (i_operand_b),
      .i_hi_we     (i_hi_we),
      .i_lo_we     (i_lo_we),
      .i_wdata     (i_wdata),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_hi        (o_hi),
      .o_lo        (o_lo)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_start     = 1'b1;
      i_op        = op;
      i_operand_a = a;
      i_operand_b = b;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int k0, output int lat_o);
      lat_o = -1;
      for (int k = k0 + 1; k <= 45; k++) begin
         @(negedge i_clk);
         if (o_done) begin
            lat_o = k;
            break;
         end
      end
   endtask

   task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e);
      int l;
      issue(op, a, b);
      wait_done(0, l);
      check({tag, "_lat"}, 64'(l), 64'd33);
      check({tag, "_hilo"}, {o_hi, o_lo}, {hi_e, lo_e});
   endtask

   initial begin
      i_rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_operand_a = '0; i_operand_b = '0;
      i_hi_we = 1'b0; i_lo_we = 1'b0; i_wdata = '0;
      repeat (3) @(negedge i_clk);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_hilo", {o_hi, o_lo}, 64'd0);
      i_rst_n = 1'b1;

      // T1: signed multiply, latency, busy, single-cycle done
      issue(OP_MULT, 32'h8000_0000, 32'd2);
      check("t1_busy", 64'(o_busy), 64'd1);
      wait_done(0, lat);
      check("t1_lat", 64'(lat), 64'd33);
      check("t1_hilo", {o_hi, o_lo}, 64'hFFFF_FFFF_0000_0000);
      @(negedge i_clk);
      check("t1_done_pulse", 64'(o_done), 64'd0);

      run_check("t2_multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_check("t2_mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_check("t3_divu", OP_DIVU, 32'd11, 32'd4, 32'd3, 32'd2);
      run_check("t3_div_neg_a", OP_DIV, 32'hFFFF_FFF0, 32'd2, 32'd0, 32'hFFFF_FFF8);
      run_check("t3_div_neg_b", OP_DIV, 32'd9, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD);
      run_check("t3_div_rem_sign", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_check("t3_div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      run_check("t4_div0", OP_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
      run_check("t4_divu0", OP_DIVU, 32'hF000_0001, 32'd0, 32'hF000_0001, 32'hFFFF_FFFF);

      // T5: start and MTHI during CALC are ignored, HI/LO hold until the update
      issue(OP_MULTU, 32'd3, 32'd5);
      repeat (9) @(negedge i_clk);
      check("t5_hold", {o_hi, o_lo}, {32'hF000_0001, 32'hFFFF_FFFF});
      i_start = 1'b1; i_op = OP_DIVU; i_operand_a = 32'd9; i_operand_b = 32'd2;
      i_hi_we = 1'b1; i_wdata = 32'h0000_DEAD;
      @(negedge i_clk);
      i_start = 1'b0; i_hi_we = 1'b0;
      check("t5_hold2", {o_hi, o_lo}, {32'hF000_0001, 32'hFFFF_FFFF});
      wait_done(10, lat);
      check("t5_lat", 64'(lat), 64'd33);
      check("t5_hilo", {o_hi, o_lo}, {32'd0, 32'd15});
      i_lo_we = 1'b1; i_wdata = 32'h0000_BEEF;
      @(negedge i_clk);
      i_lo_we = 1'b0;
      check("t5_mtlo", {o_hi, o_lo}, {32'd0, 32'h0000_BEEF});
      check("t5_idle_busy", 64'(o_busy), 64'd0);

      // simultaneous MTHI/MTLO, then start wins over a same-edge write
      i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hCAFE_0001;
      @(negedge i_clk);
      i_hi_we = 1'b0; i_lo_we = 1'b0;
      check("both_we", {o_hi, o_lo}, {32'hCAFE_0001, 32'hCAFE_0001});
      i_start = 1'b1; i_op = OP_MULTU; i_operand_a = 32'd6; i_operand_b = 32'd7;
      i_hi_we = 1'b1; i_wdata = 32'h1111_1111;
      @(negedge i_clk);
      i_start = 1'b0; i_hi_we = 1'b0;
      check("start_wins_hold", {o_hi, o_lo}, {32'hCAFE_0001, 32'hCAFE_0001});
      check("start_wins_busy", 64'(o_busy), 64'd1);
      wait_done(0, lat);
      check("start_wins_lat", 64'(lat), 64'd33);
      check("start_wins_hilo", {o_hi, o_lo}, {32'd0, 32'd42});

      // T6: reset mid-operation
      issue(OP_MULT, 32'd7, 32'd7);
      repeat (14) @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      check("t6_rst_busy", 64'(o_busy), 64'd0);
      check("t6_rst_hilo", {o_hi, o_lo}, 64'd0);
      repeat (2) @(negedge i_clk);
      check("t6_rst_done", 64'(o_done), 64'd0);
      i_rst_n = 1'b1;
      run_check("t6_after", OP_MULT, 32'd7, 32'd7, 32'd0, 32'd49);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
